// File: rtl/ahb_grant_ctrl_if.sv
// Grant-control bus bundle: AHB handshake/response inputs, the request
// judge's grant request, and the registered grant/ownership outputs.
interface ahb_grant_ctrl_if #(
  parameter int NUM_MST = 5
);
  logic               hready;
  logic [1:0]         htrans;
  logic [2:0]         hburst;
  logic [1:0]         hresp;
  logic [NUM_MST-1:0] hsplit;
  logic [NUM_MST-1:0] grant_req;
  logic               lock_req;
  logic [NUM_MST-1:0] hgrant;
  logic [2:0]         hmaster;
  logic [2:0]         hmaster_d;
  logic               hmastlock;
  logic [NUM_MST-1:0] split_mask;

  // Driving side: bus/judge environment
  modport master (
    output hready, htrans, hburst, hresp, hsplit, grant_req, lock_req,
    input  hgrant, hmaster, hmaster_d, hmastlock, split_mask
  );

  // Receiving side: the grant-control stage
  modport slave (
    input  hready, htrans, hburst, hresp, hsplit, grant_req, lock_req,
    output hgrant, hmaster, hmaster_d, hmastlock, split_mask
  );
endinterface

// File: rtl/ahb_grant_ctrl.sv
// Registered grant-control stage for the 5-master AHB arbiter. Holds the
// grant across fixed-length bursts and locked sequences, tracks the
// address/data-phase owners, and parks SPLIT masters until released.
module ahb_grant_ctrl #(
  parameter int NUM_MST = 5,
  parameter int DEF_MST = 0
) (
  input  logic hclk,
  input  logic hreset,
  ahb_grant_ctrl_if.slave bus
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [1:0] RSP_OKAY  = 2'd0;
  localparam logic [1:0] RSP_SPLIT = 2'd3;

  localparam logic [NUM_MST-1:0] DEF_GRANT = NUM_MST'(1) << DEF_MST;
  localparam logic [2:0]         DEF_IDX   = 3'(DEF_MST);

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [NUM_MST-1:0] r_hgrant, w_hgrant_nxt;
  logic [2:0]         r_hmaster;
  logic [2:0]         r_hmaster_d;
  logic               r_hmastlock;
  logic [NUM_MST-1:0] r_split_mask, w_split_nxt;
  logic [NUM_MST-1:0] w_elig;
  logic [NUM_MST-1:0] w_arb;
  logic [NUM_MST-1:0] w_split_set;
  logic [2:0]         w_grant_idx;
  logic               w_err_first;
  logic               w_split_cap;
  logic               w_rearb;

  assign w_elig      = bus.grant_req & ~r_split_mask;
  assign w_err_first = !bus.hready && (bus.hresp != RSP_OKAY);
  assign w_split_cap = bus.hready && (bus.hresp == RSP_SPLIT);

  // Lowest-index eligible master wins; default master when nobody is eligible
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    w_arb = DEF_GRANT;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_arb    = '0;
        w_arb[i] = 1'b1;
      end
    end
  end

  // Binary index of the current one-hot grant
  always_comb begin
    w_grant_idx = DEF_IDX;
    for (int i = 0; i < NUM_MST; i++) begin
      if (r_hgrant[i]) w_grant_idx = 3'(i);
    end
  end

  // Split mask: release pulses clear first, a captured SPLIT then sets
  always_comb begin
    w_split_set = '0;
    if (w_split_cap && (int'(r_hmaster_d) < NUM_MST)) w_split_set[r_hmaster_d] = 1'b1;
    w_split_nxt = (r_split_mask & ~bus.hsplit) | w_split_set;
  end

  // Next-state, beat counter and grant selection
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hgrant_nxt = r_hgrant;
    w_rearb      = 1'b0;
    if (bus.hready) begin
      unique case (r_state)
        ST_ARB: begin
          w_rearb = 1'b1;
          if (bus.lock_req) begin
            w_state_nxt = ST_LOCKED;
          end else if (bus.htrans == TR_NONSEQ && bus.hburst[2:1] != 2'b00) begin
            w_state_nxt = ST_BURST;
            unique case (bus.hburst[2:1])
              2'b01:   w_cnt_nxt = 4'd3;
              2'b10:   w_cnt_nxt = 4'd7;
              default: w_cnt_nxt = 4'd15;
            endcase
          end
        end
        ST_BURST: begin
          unique case (bus.htrans)
            TR_SEQ: begin
              if (r_cnt == 4'd1) begin
                w_state_nxt = ST_ARB;
                w_rearb     = 1'b1;
              end else begin
                w_cnt_nxt = r_cnt - 4'd1;
              end
            end
            TR_BUSY: ;
            default: begin
              w_state_nxt = ST_ARB;
              w_rearb     = 1'b1;
            end
          endcase
        end
        ST_LOCKED: begin
          if (w_split_cap || (!bus.lock_req && bus.htrans != TR_SEQ)) begin
            w_state_nxt = ST_ARB;
            w_rearb     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_ARB;
          w_rearb     = 1'b1;
        end
      endcase
    end else if (r_state == ST_BURST && w_err_first) begin
      // Abort the burst on the first error cycle; grant moves on the next accepted edge
      w_state_nxt = ST_ARB;
    end
    if (w_rearb) w_hgrant_nxt = w_arb;
  end

  // State, grant and ownership pipeline registers
  always_ff @(posedge hclk) begin
    // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
    if (hreset) begin
      r_state      <= ST_ARB;
      r_cnt        <= '0;
      r_hgrant     <= DEF_GRANT;
      r_hmaster    <= DEF_IDX;
      r_hmaster_d  <= DEF_IDX;
      r_hmastlock  <= 1'b0;
      r_split_mask <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values (hmaster_d gets the old hmaster).
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hgrant     <= w_hgrant_nxt;
      r_split_mask <= w_split_nxt;
      if (bus.hready) begin
        r_hmaster   <= w_grant_idx;
        r_hmaster_d <= r_hmaster;
        r_hmastlock <= (r_state == ST_LOCKED) || (r_state == ST_ARB && bus.lock_req);
      end
    end
  end

  assign bus.hgrant     = r_hgrant;
  assign bus.hmaster    = r_hmaster;
  assign bus.hmaster_d  = r_hmaster_d;
  assign bus.hmastlock  = r_hmastlock;
  assign bus.split_mask = r_split_mask;

endmodule

// File: tb/tb_ahb_grant_ctrl.sv
// Directed bench for ahb_grant_ctrl: each vector pushes its hand-computed
// post-edge outputs into a queue; a monitor pops one entry after every
// rising edge and compares.
module tb_ahb_grant_ctrl;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SNGL = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;
  localparam logic [1:0] OK = 2'd0, RTY = 2'd2, SPL = 2'd3;

  typedef struct {
    int         id;
    logic [4:0] grant;
    logic [2:0] mst;
    logic [2:0] mst_d;
    logic       lock;
    logic [4:0] mask;
  } exp_t;

  logic hclk;
  logic hreset;
  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;
  int   vid;

  ahb_grant_ctrl_if #(.NUM_MST(5)) bus ();

  ahb_grant_ctrl #(.NUM_MST(5), .DEF_MST(0)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input int id, input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL v%0d %s got %b want %b", id, name, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs
  task automatic vec(input logic rst, input logic rdy, input logic [1:0] tr, input logic [2:0] bu,
                     input logic [1:0] rs, input logic [4:0] spl, input logic [4:0] greq,
                     input logic lk, input logic [4:0] eg, input logic [2:0] em,
                     input logic [2:0] emd, input logic el, input logic [4:0] emask);
    exp_t e;
    @(negedge hclk);
    vid++;
    hreset        = rst;
    bus.hready    = rdy;
    bus.htrans    = tr;
    bus.hburst    = bu;
    bus.hresp     = rs;
    bus.hsplit    = spl;
    bus.grant_req = greq;
    bus.lock_req  = lk;
    e.id = vid; e.grant = eg; e.mst = em; e.mst_d = emd; e.lock = el; e.mask = emask;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.id, "hgrant",     {3'b0, bus.hgrant},     {3'b0, e.grant});
        check(e.id, "hmaster",    {5'b0, bus.hmaster},    {5'b0, e.mst});
        check(e.id, "hmaster_d",  {5'b0, bus.hmaster_d},  {5'b0, e.mst_d});
        check(e.id, "hmastlock",  {7'b0, bus.hmastlock},  {7'b0, e.lock});
        check(e.id, "split_mask", {3'b0, bus.split_mask}, {3'b0, e.mask});
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vid     = 0;
    hreset = 1'b1; bus.hready = 1'b1; bus.htrans = IDLE; bus.hburst = SNGL;
    bus.hresp = OK; bus.hsplit = '0; bus.grant_req = '0; bus.lock_req = 1'b0;

    //  rst rdy tr    burst   resp spl       greq      lk  grant     m  md lk mask
    // Reset and idle default grant
    vec(1, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00000, 0, 5'b00001, 0, 0, 0, 5'b00000);
    vec(1, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00000, 0, 5'b00001, 0, 0, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00000, 0, 5'b00001, 0, 0, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00000, 0, 5'b00001, 0, 0, 0, 5'b00000);
    // INCR4: grant held, handover on the edge accepting beat 4
    vec(0, 1, NS,   INCR4,  OK,  5'b00000, 5'b00100, 0, 5'b00100, 0, 0, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR4,  OK,  5'b00000, 5'b01000, 0, 5'b00100, 2, 0, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR4,  OK,  5'b00000, 5'b01000, 0, 5'b00100, 2, 2, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR4,  OK,  5'b00000, 5'b01000, 0, 5'b01000, 2, 2, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b01000, 0, 5'b01000, 3, 2, 0, 5'b00000);
    // INCR8 with a BUSY beat and two wait states
    vec(0, 1, NS,   INCR8,  OK,  5'b00000, 5'b01000, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, BUSY, INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 0, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 0, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 3, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR8,  OK,  5'b00000, 5'b00010, 0, 5'b00010, 3, 3, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00010, 0, 5'b00010, 1, 3, 0, 5'b00000);
    // Locked sequence: grant frozen, exit only on non-SEQ with lock released
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00010, 1, 5'b00010, 1, 1, 1, 5'b00000);
    vec(0, 1, NS,   INCR,   OK,  5'b00000, 5'b10000, 1, 5'b00010, 1, 1, 1, 5'b00000);
    vec(0, 1, SEQ,  INCR,   OK,  5'b00000, 5'b10000, 1, 5'b00010, 1, 1, 1, 5'b00000);
    vec(0, 1, SEQ,  INCR,   OK,  5'b00000, 5'b10000, 1, 5'b00010, 1, 1, 1, 5'b00000);
    vec(0, 1, NS,   SNGL,   OK,  5'b00000, 5'b10000, 1, 5'b00010, 1, 1, 1, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b10000, 1, 5'b00010, 1, 1, 1, 5'b00000);
    vec(0, 1, SEQ,  INCR,   OK,  5'b00000, 5'b10000, 0, 5'b00010, 1, 1, 1, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b10000, 0, 5'b10000, 1, 1, 1, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b10000, 0, 5'b10000, 4, 1, 0, 5'b00000);
    // Move master 2 into the data phase
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00100, 0, 5'b00100, 4, 4, 0, 5'b00000);
    vec(0, 1, NS,   SNGL,   OK,  5'b00000, 5'b00100, 0, 5'b00100, 2, 4, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00100, 0, 5'b00100, 2, 2, 0, 5'b00000);
    // SPLIT capture, masked request falls back to default, release, regrant
    vec(0, 0, IDLE, SNGL,   SPL, 5'b00000, 5'b00100, 0, 5'b00100, 2, 2, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   SPL, 5'b00000, 5'b00100, 0, 5'b00100, 2, 2, 0, 5'b00100);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00100, 0, 5'b00001, 2, 2, 0, 5'b00100);
    vec(0, 0, IDLE, SNGL,   OK,  5'b00100, 5'b00100, 0, 5'b00001, 2, 2, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00100, 0, 5'b00100, 0, 2, 0, 5'b00000);
    // Same-cycle set and release of one bit: set wins
    vec(0, 1, IDLE, SNGL,   SPL, 5'b00100, 5'b00100, 0, 5'b00100, 2, 0, 0, 5'b00100);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00100, 5'b00100, 0, 5'b00001, 2, 2, 0, 5'b00000);
    // INCR16 aborted by RETRY in its first response cycle
    vec(0, 1, NS,   INCR16, OK,  5'b00000, 5'b01000, 0, 5'b01000, 0, 2, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR16, OK,  5'b00000, 5'b00010, 0, 5'b01000, 3, 0, 0, 5'b00000);
    vec(0, 0, SEQ,  INCR16, RTY, 5'b00000, 5'b00010, 0, 5'b01000, 3, 0, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR16, RTY, 5'b00000, 5'b00010, 0, 5'b00010, 3, 3, 0, 5'b00000);
    // LOCKED holds on RETRY, exits on SPLIT capture
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b10000, 1, 5'b10000, 1, 3, 1, 5'b00000);
    vec(0, 0, SEQ,  INCR,   RTY, 5'b00000, 5'b00001, 1, 5'b10000, 1, 3, 1, 5'b00000);
    vec(0, 1, NS,   INCR,   RTY, 5'b00000, 5'b00001, 1, 5'b10000, 4, 1, 1, 5'b00000);
    vec(0, 1, IDLE, SNGL,   SPL, 5'b00000, 5'b00001, 1, 5'b00001, 4, 4, 1, 5'b00010);
    // Only request is masked: default master granted; then lock again
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00010, 1, 5'b00001, 0, 4, 1, 5'b00010);
    vec(0, 1, SEQ,  INCR,   OK,  5'b00000, 5'b00010, 1, 5'b00001, 0, 0, 1, 5'b00010);
    // Reset mid-LOCKED aborts everything
    vec(1, 1, SEQ,  INCR,   OK,  5'b00000, 5'b01000, 1, 5'b00001, 0, 0, 0, 5'b00000);
    vec(0, 1, SEQ,  INCR,   OK,  5'b00000, 5'b01000, 0, 5'b01000, 0, 0, 0, 5'b00000);
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b00000, 0, 5'b00001, 3, 0, 0, 5'b00000);
    // Multi-hot request: lowest index wins
    vec(0, 1, IDLE, SNGL,   OK,  5'b00000, 5'b10100, 0, 5'b00100, 0, 3, 0, 5'b00000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge hclk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
